// File: rtl/l1_mem_arb.sv
// rtl/l1_mem_arb.sv - Two-port (L1I/L1D) arbiter onto a single memory request/response port
//
// One transaction outstanding at a time: IDLE grants a requester, REQ presents the
// latched request until memory accepts it, RESP waits for the memory response and
// routes it to the owner. Collisions are resolved round-robin (D first after reset).
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   i_req_val/addr, i_req_ack     L1I refill request and its 1-cycle accept pulse
//   i_ack_val/data                L1I response
//   d_req_val/addr/cop/wdata/be   L1D request (cop 0 = read, 1 = write)
//   d_req_ack                     L1D accept pulse
//   d_ack_val/data                L1D response (read data or write done)
//   mem_req_*                     latched request towards memory, mem_req_ack accepts it
//   mem_ack_val/data              memory response
//   arb_timeout                   sticky response-watchdog flag
//
// Optional feature: define L1_ARB_TIMEOUT_EN to enable the RESP watchdog, which answers
// the owner with data 0 after TIMEOUT_CYCLES cycles in RESP and sets arb_timeout.

module l1_mem_arb #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_req_val,
    input  logic [ADDR_WIDTH-1:0]   i_req_addr,
    output logic                    i_req_ack,
    output logic                    i_ack_val,
    output logic [DATA_WIDTH-1:0]   i_ack_data,
    input  logic                    d_req_val,
    input  logic [ADDR_WIDTH-1:0]   d_req_addr,
    input  logic                    d_req_cop,
    input  logic [DATA_WIDTH-1:0]   d_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_req_be,
    output logic                    d_req_ack,
    output logic                    d_ack_val,
    output logic [DATA_WIDTH-1:0]   d_ack_data,
    output logic                    mem_req_val,
    input  logic                    mem_req_ack,
    output logic [ADDR_WIDTH-1:0]   mem_req_addr,
    output logic                    mem_req_cop,
    output logic [DATA_WIDTH-1:0]   mem_req_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_req_be,
    input  logic                    mem_ack_val,
    input  logic [DATA_WIDTH-1:0]   mem_ack_data,
    output logic                    arb_timeout
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic                    owner_d;   // 1: current transaction belongs to L1D
    logic                    last_d;    // 1: L1D was served last, so L1I wins a collision
    logic                    grant_i;
    logic                    grant_d;
    logic                    timeout_hit;
    logic                    resp_done;
    logic [ADDR_WIDTH-1:0]   lat_addr;
    logic                    lat_cop;
    logic [DATA_WIDTH-1:0]   lat_wdata;
    logic [BE_WIDTH-1:0]     lat_be;

    // A response completes on a real memory ack or on a watchdog expiry.
    assign resp_done = (state == S_RESP) && (mem_ack_val || timeout_hit);

    // State register plus the request latch and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            owner_d   <= 1'b0;
            last_d    <= 1'b0;
            lat_addr  <= '0;
            lat_cop   <= 1'b0;
            lat_wdata <= '0;
            lat_be    <= '0;
        end else begin
            state <= state_nxt;
            if (grant_d) begin
                owner_d   <= 1'b1;
                lat_addr  <= d_req_addr;
                lat_cop   <= d_req_cop;
                lat_wdata <= d_req_wdata;
                lat_be    <= d_req_be;
            end else if (grant_i) begin
                // Instruction refills are always full-width reads.
                owner_d   <= 1'b0;
                lat_addr  <= i_req_addr;
                lat_cop   <= 1'b0;
                lat_wdata <= '0;
                lat_be    <= '1;
            end
            if (resp_done) begin
                last_d <= owner_d;
            end
        end
    end

    // Next-state and grant selection.
    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        case (state)
            S_IDLE: begin
                if (d_req_val && (!i_req_val || !last_d)) begin
                    grant_d = 1'b1;
                end else if (i_req_val) begin
                    grant_i = 1'b1;
                end
                if (grant_i || grant_d) begin
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_req_ack) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_done) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs. Everything handshake-related is held low while rst is high so a
    // reset cycle can never leak an accept or a response.
    always_comb begin
        i_req_ack   = grant_i && !rst;
        d_req_ack   = grant_d && !rst;
        mem_req_val = (state == S_REQ) && !rst;
        i_ack_val   = resp_done && !owner_d && !rst;
        d_ack_val   = resp_done && owner_d && !rst;
        // On a watchdog expiry mem_ack_val is low, so the owner sees data 0.
        i_ack_data  = (i_ack_val && mem_ack_val) ? mem_ack_data : '0;
        d_ack_data  = (d_ack_val && mem_ack_val) ? mem_ack_data : '0;
    end

    assign mem_req_addr  = lat_addr;
    assign mem_req_cop   = lat_cop;
    assign mem_req_wdata = lat_wdata;
    assign mem_req_be    = lat_be;

`ifdef L1_ARB_TIMEOUT_EN
    localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [CNT_WIDTH-1:0] wd_cnt;   // RESP cycles already elapsed
    logic                 wd_flag;

    // Fires during the TIMEOUT_CYCLES-th cycle spent in RESP.
    assign timeout_hit = (state == S_RESP) && !mem_ack_val && (wd_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt  <= '0;
            wd_flag <= 1'b0;
        end else begin
            // Held at zero outside RESP, so it is clear on every RESP entry.
            if (state != S_RESP) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (timeout_hit) begin
                wd_flag <= 1'b1;
            end
        end
    end

    assign arb_timeout = wd_flag;
`else
    assign timeout_hit = 1'b0;
    assign arb_timeout = 1'b0;
`endif

endmodule

// File: doc/l1_mem_arb.md
L1_MEM_ARB -- requirements
Module: l1_mem_arb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, the request address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, the write and read data width; byte-enable width is DATA_WIDTH/8.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, the response watchdog limit (used only with L1_ARB_TIMEOUT_EN).
REQ-004 SHALL have ports, one clock, reset synchronous and active-high:
 clk  in  1  clock, all state on rising edge
 rst  in  1  synchronous active-high reset
 i_req_val  in  1  L1I refill request, held until i_req_ack
 i_req_addr  in  ADDR_WIDTH  L1I address
 i_req_ack  out  1  L1I request accepted, 1-cycle pulse
 i_ack_val  out  1  L1I response valid
 i_ack_data  out  DATA_WIDTH  L1I read data
 d_req_val  in  1  L1D request, held until d_req_ack
 d_req_addr  in  ADDR_WIDTH  L1D address
 d_req_cop  in  1  0 = read, 1 = write
 d_req_wdata  in  DATA_WIDTH  L1D write data
 d_req_be  in  DATA_WIDTH/8  L1D byte enables
 d_req_ack  out  1  L1D request accepted, 1-cycle pulse
 d_ack_val  out  1  L1D response valid (read data or write done)
 d_ack_data  out  DATA_WIDTH  L1D read data
 mem_req_val  out  1  memory request valid
 mem_req_ack  in  1  memory accepts request
 mem_req_addr/cop/wdata/be  out  as above  latched request fields
 mem_ack_val  in  1  memory response valid
 mem_ack_data  in  DATA_WIDTH  memory read data
 arb_timeout  out  1  sticky watchdog flag

Function
REQ-005 SHALL implement FSM IDLE -> REQ -> RESP -> IDLE, with only one transaction outstanding.
REQ-006 In IDLE with at least one *_req_val, SHALL grant one requester, pulse its *_req_ack combinationally that cycle, latch addr/cop/wdata/be and owner, and enter REQ.
REQ-007 The I request SHALL be latched with cop=0 and be all-ones.
REQ-008 On a collision (both valid in IDLE), SHALL grant round-robin: the requester not served last wins; after reset D wins.
REQ-009 In REQ, mem_req_val SHALL be 1 with the latched fields stable; on mem_req_ack=1, SHALL enter RESP next cycle.
REQ-010 In RESP, on mem_ack_val=1, SHALL drive the owner's *_ack_val=1 and *_ack_data=mem_ack_data in the same cycle, update the round-robin pointer to the owner, and enter IDLE.
REQ-011 mem_ack_val outside RESP SHALL be ignored, with no *_ack_val.
REQ-012 The non-owner *_ack_val SHALL be 0; *_ack_data SHALL be 0 when the matching *_ack_val is 0.
REQ-013 Minimum latency SHALL be: grant at cycle N, mem_req_val at N+1, response returned at N+2 if memory acks immediately, next grant at N+3.
REQ-014 A requester dropping *_req_val before ack SHALL be permitted; nothing is latched for it.

Reset
REQ-015 On rst=1 at the clock edge, SHALL go to IDLE from any state, including mid-transaction.
REQ-016 Reset SHALL drive mem_req_val=0, all *_req_ack and *_ack_val=0, latched fields=0, round-robin pointer favouring D, watchdog counter=0, and arb_timeout=0.
REQ-017 A transaction in flight at reset SHALL be dropped with no response to any requester.

Configuration
REQ-018 With macro L1_ARB_TIMEOUT_EN defined, SHALL count cycles spent in RESP; when the count reaches TIMEOUT_CYCLES without mem_ack_val, SHALL:
 - pulse the owner's *_ack_val with data 0
 - set arb_timeout=1 (sticky until rst)
 - enter IDLE
REQ-019 With L1_ARB_TIMEOUT_EN defined, the counter SHALL clear on entry to RESP.
REQ-020 Without L1_ARB_TIMEOUT_EN, RESP SHALL wait indefinitely, arb_timeout SHALL be tied 0, and no counter logic SHALL exist.

Verification
REQ-021 Bench SHALL cover: d read addr 0x100, mem acks at once, data 0xDEADBEEF -> d_req_ack at N, mem_req_val N+1, d_ack_val with 0xDEADBEEF at N+2.
REQ-022 Bench SHALL cover: i and d valid together after reset -> D granted first, I second, D third if both keep requesting.
REQ-023 Bench SHALL cover: d write addr 0x40, wdata 0x12345678, be 0x3, mem_req_ack delayed 5 cycles -> mem fields stable all 5 cycles, then d_ack_val on mem_ack_val.
REQ-024 Bench SHALL cover: stray mem_ack_val in IDLE -> no i_ack_val or d_ack_val.
REQ-025 Bench SHALL cover: rst asserted in RESP -> IDLE next cycle, no ack, and a subsequent request completes normally.
REQ-026 Bench SHALL cover, with L1_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8: no mem_ack_val -> owner ack with data 0 after 8 RESP cycles, arb_timeout=1 and held.
